// File: rtl/conv2d_0_pkg.sv
// Shared layer constants and state encodings for the conv2d_0 filter scheduler.
package conv2d_0_pkg;

    localparam int DWIDTH_DEF      = 32;
    localparam int NUM_FILTERS_DEF = 4;
    localparam int IN_PIXELS_DEF   = 12544;   // 112x112 input image
    localparam int OUT_PIXELS_DEF  = 12100;   // 110x110 valid 3x3 output

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        G_REQ  = 2'd0,
        G_CAP  = 2'd1,
        G_HOLD = 2'd2
    } gather_state_t;

    // Filter select width; a single filter still needs a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2d_0_result_gather.sv
// Round-robin gather of per-filter results into one channel-interleaved stream.
module conv2d_0_result_gather
    import conv2d_0_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int OUT_PIXELS  = OUT_PIXELS_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    input  logic                          i_run,
    input  logic [NUM_FILTERS*DWIDTH-1:0] i_f_out_data,
    input  logic [NUM_FILTERS-1:0]        i_f_out_empty,
    output logic [NUM_FILTERS-1:0]        o_f_out_rdreq,
    output logic [DWIDTH-1:0]             o_m_data,
    output logic                          o_m_valid,
    output logic                          o_m_last,
    input  logic                          i_m_ready,
    output logic                          o_all_out,
    output logic                          o_last_acc
);

    localparam int TOTAL = OUT_PIXELS * NUM_FILTERS;
    localparam int OCW   = $clog2(TOTAL + 1);
    localparam int SW    = sel_width(NUM_FILTERS);

    localparam logic [OCW-1:0] W_TOTAL    = OCW'(TOTAL);
    localparam logic [OCW-1:0] W_TOTAL_M1 = OCW'(TOTAL - 1);
    localparam logic [SW-1:0]  W_SEL_MAX  = SW'(NUM_FILTERS - 1);

    gather_state_t     r_gst;
    gather_state_t     w_gst_nxt;
    logic [SW-1:0]     r_sel;
    logic [OCW-1:0]    r_out_cnt;
    logic [DWIDTH-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;
    logic [DWIDTH-1:0] w_sel_data;
    logic              w_sel_empty;
    logic              w_pending;
    logic              w_accept;

    assign w_pending  = (r_out_cnt < W_TOTAL);
    assign w_accept   = (r_gst == G_HOLD) && i_m_ready;
    assign o_all_out  = (r_out_cnt == W_TOTAL);
    assign o_last_acc = w_accept && r_m_last;
    assign o_m_data   = r_m_data;
    assign o_m_valid  = r_m_valid;
    assign o_m_last   = r_m_last;

    // Mux out the currently selected filter's result word and empty flag.
    always_comb begin
        w_sel_data  = '0;
        w_sel_empty = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (r_sel == SW'(i)) begin
                w_sel_data  = i_f_out_data[i*DWIDTH +: DWIDTH];
                w_sel_empty = i_f_out_empty[i];
            end
        end
    end

    // Gather state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gst <= G_REQ;
        end else begin
            r_gst <= w_gst_nxt;
        end
    end

    // Next gather state; the read strobe is a single-cycle pulse out of G_REQ.
    always_comb begin
        w_gst_nxt     = r_gst;
        o_f_out_rdreq = '0;
        case (r_gst)
            G_REQ: begin
                if (i_run && w_pending && !w_sel_empty) begin
                    o_f_out_rdreq = NUM_FILTERS'(1) << r_sel;
                    w_gst_nxt     = G_CAP;
                end
            end
            G_CAP:   w_gst_nxt = G_HOLD;
            G_HOLD:  if (i_m_ready) w_gst_nxt = G_REQ;
            default: w_gst_nxt = G_REQ;
        endcase
        if (i_clear) begin
            w_gst_nxt = G_REQ;
        end
    end

    // Output register: capture one cycle after the read, hold until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (i_clear) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (r_gst == G_CAP) begin
            r_m_data  <= w_sel_data;
            r_m_valid <= 1'b1;
            r_m_last  <= (r_out_cnt == W_TOTAL_M1);
        end else if (w_accept) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    // Word counter and round-robin filter select advance on each accepted word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel     <= '0;
            r_out_cnt <= '0;
        end else if (i_clear) begin
            r_sel     <= '0;
            r_out_cnt <= '0;
        end else if (w_accept) begin
            r_out_cnt <= r_out_cnt + OCW'(1);
            r_sel     <= (r_sel == W_SEL_MAX) ? '0 : r_sel + SW'(1);
        end
    end

endmodule

// File: rtl/conv2d_0_filter_scheduler.sv
// Sequences one conv2d_0 pass: broadcasts input pixels to all filters and
// gathers their results into one HWC output stream.
module conv2d_0_filter_scheduler
    import conv2d_0_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int IN_PIXELS   = IN_PIXELS_DEF,
    parameter int OUT_PIXELS  = OUT_PIXELS_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic [DWIDTH*3-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DWIDTH*3-1:0]           f_in_data,
    output logic [NUM_FILTERS-1:0]        f_in_wrreq,
    input  logic [NUM_FILTERS-1:0]        f_in_full,
    input  logic [NUM_FILTERS*DWIDTH-1:0] f_out_data,
    output logic [NUM_FILTERS-1:0]        f_out_rdreq,
    input  logic [NUM_FILTERS-1:0]        f_out_empty,
    output logic [DWIDTH-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last
);

    localparam int ICW = $clog2(IN_PIXELS + 1);
    localparam logic [ICW-1:0] W_IN_MAX = ICW'(IN_PIXELS);

    top_state_t     r_state;
    top_state_t     w_state_nxt;
    logic [ICW-1:0] r_in_cnt;
    logic           w_run;
    logic           w_clear;
    logic           w_in_done;
    logic           w_accept_in;
    logic           w_all_out;
    logic           w_last_acc;

    assign w_run       = (r_state == T_RUN);
    assign w_clear     = (r_state == T_IDLE) && start;
    assign w_in_done   = (r_in_cnt == W_IN_MAX);
    // One full filter stalls the broadcast for all, so no filter sees a partial stream.
    assign s_ready     = w_run && !w_in_done && !(|f_in_full);
    assign w_accept_in = s_valid && s_ready;
    assign f_in_wrreq  = {NUM_FILTERS{w_accept_in}};
    assign f_in_data   = s_data;
    assign busy        = (r_state != T_IDLE);
    assign done        = (r_state == T_DONE);

    // Top state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= T_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pass sequencing; the pass ends as the final output word is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            T_IDLE:  if (start) w_state_nxt = T_RUN;
            T_RUN:   if (w_in_done && (w_all_out || w_last_acc)) w_state_nxt = T_DONE;
            T_DONE:  w_state_nxt = T_IDLE;
            default: w_state_nxt = T_IDLE;
        endcase
    end

    // Input pixel counter; s_ready drops at the limit, so it saturates there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_cnt <= '0;
        end else if (w_clear) begin
            r_in_cnt <= '0;
        end else if (w_accept_in) begin
            r_in_cnt <= r_in_cnt + ICW'(1);
        end
    end

    conv2d_0_result_gather #(
        .DWIDTH      (DWIDTH),
        .NUM_FILTERS (NUM_FILTERS),
        .OUT_PIXELS  (OUT_PIXELS)
    ) u_gather (
        .i_clk         (clock),
        .i_rst_n       (reset),
        .i_clear       (w_clear),
        .i_run         (w_run),
        .i_f_out_data  (f_out_data),
        .i_f_out_empty (f_out_empty),
        .o_f_out_rdreq (f_out_rdreq),
        .o_m_data      (m_data),
        .o_m_valid     (m_valid),
        .o_m_last      (m_last),
        .i_m_ready     (m_ready),
        .o_all_out     (w_all_out),
        .o_last_acc    (w_last_acc)
    );

endmodule

// File: tb/tb_conv2d_0_filter_scheduler.sv
`timescale 1ns/1ps
module tb_conv2d_0_filter_scheduler;

    localparam int DW    = 32;
    localparam int NF    = 2;
    localparam int INP   = 16;
    localparam int OUTP  = 4;
    localparam int TOTAL = NF * OUTP;
    localparam int RATIO = INP / OUTP;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, s_ready, m_valid, m_last;
    logic             s_valid = 1'b0;
    logic             m_ready = 1'b0;
    logic [DW*3-1:0]  s_data = '0;
    logic [DW*3-1:0]  f_in_data;
    logic [NF-1:0]    f_in_wrreq, f_out_rdreq;
    logic [NF-1:0]    f_in_full = '0;
    logic [NF-1:0]    f_out_empty = '1;
    logic [NF*DW-1:0] f_out_data = '0;
    logic [DW-1:0]    m_data;

    always #5 clock = ~clock;

    conv2d_0_filter_scheduler #(
        .DWIDTH(DW), .NUM_FILTERS(NF), .IN_PIXELS(INP), .OUT_PIXELS(OUTP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_in_data(f_in_data), .f_in_wrreq(f_in_wrreq), .f_in_full(f_in_full),
        .f_out_data(f_out_data), .f_out_rdreq(f_out_rdreq), .f_out_empty(f_out_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    int errors = 0;
    int checks = 0;

    // Filter FIFO model: filter i emits i*100+k for its k-th result, one result per RATIO inputs.
    int            rcv[NF];
    int            popped[NF];
    logic [NF-1:0] pend_rd = '0;
    logic [NF-1:0] pend_wr = '0;
    logic [NF-1:0] force_empty = '0;

    // Pass-level model.
    bit          m_busy = 0;
    int          m_sent = 0;
    int          m_acc = 0;
    bit          prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    int          got[$];
    int          cyc_cnt = 0;
    int          last_acc_cyc = 0;
    int          done_cyc = 0;
    int          n_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_word(input int n);
        return (n % NF) * 100 + n / NF;
    endfunction

    task automatic upd_empty();
        for (int i = 0; i < NF; i++) begin
            int av;
            av = ((rcv[i] / RATIO > OUTP) ? OUTP : rcv[i] / RATIO) - popped[i];
            f_out_empty[i] = force_empty[i] || (av <= 0);
        end
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NF; i++) begin
            rcv[i] = 0;
            popped[i] = 0;
        end
        pend_rd = '0;
        pend_wr = '0;
        f_out_data = '0;
        upd_empty();
    endtask

    // Filter FIFOs: writes land and reads return data one cycle after the strobe.
    always @(posedge clock) begin
        #2;
        for (int i = 0; i < NF; i++) begin
            if (pend_wr[i]) rcv[i]++;
            if (pend_rd[i]) begin
                f_out_data[i*DW +: DW] = DW'(i * 100 + popped[i]);
                popped[i]++;
            end
        end
        pend_wr = '0;
        pend_rd = '0;
        upd_empty();
    end

    // Compare process: checks outputs each cycle, then advances the model across the next edge.
    always @(negedge clock) begin
        bit was_busy, exp_sready, exp_done;
        cyc_cnt++;
        if (!reset) begin
            m_busy = 0; m_sent = 0; m_acc = 0; prev_hold = 0;
            pend_rd = '0; pend_wr = '0;
        end else begin
            was_busy   = m_busy;
            exp_sready = m_busy && (m_sent < INP) && (f_in_full == '0);
            exp_done   = m_busy && (m_sent == INP) && (m_acc == TOTAL);
            chk("busy", busy, m_busy);
            chk("s_ready", s_ready, exp_sready);
            chk("f_in_wrreq", f_in_wrreq, {NF{s_valid && exp_sready}});
            if (|f_in_wrreq) chk("f_in_data", f_in_data, s_data);
            chk("rdreq_onehot", ($countones(f_out_rdreq) > 1), 1'b0);
            chk("rdreq_on_empty", |(f_out_rdreq & f_out_empty), 1'b0);
            chk("done", done, exp_done);
            if (!m_busy) chk("m_valid_idle", m_valid, 1'b0);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                chk("word_count_bound", (m_acc < TOTAL), 1'b1);
                chk("m_data", m_data, exp_word(m_acc));
                chk("m_last", m_last, (m_acc == TOTAL - 1));
            end else begin
                chk("m_last_idle", m_last, 1'b0);
            end
            pend_wr = f_in_wrreq;
            pend_rd = f_out_rdreq;
            if (s_valid && exp_sready) m_sent++;
            if (m_valid && m_ready) begin
                got.push_back(int'(m_data));
                m_acc++;
                if (m_acc == TOTAL) last_acc_cyc = cyc_cnt;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (done) begin
                n_done++;
                done_cyc = cyc_cnt;
            end
            if (exp_done) m_busy = 0;
            if (!was_busy && start) begin
                m_busy = 1; m_sent = 0; m_acc = 0;
            end
        end
    end

    task automatic drive(input int mode, input int cyc);
        s_data = {$urandom, $urandom, $urandom};
        start  = 1'b0;
        case (mode)
            1, 5: begin
                s_valid = 1'b1; m_ready = 1'b1; f_in_full = '0; force_empty = '0;
            end
            2: begin
                s_valid = 1'b1; m_ready = 1'b1; force_empty = '0;
                f_in_full = (cyc >= 5 && cyc <= 9) ? 2'b10 : 2'b00;
            end
            3: begin
                s_valid = ($urandom % 4) != 0;
                m_ready = (cyc >= 10 && cyc < 30) ? 1'b0 : 1'($urandom % 2);
                for (int i = 0; i < NF; i++) f_in_full[i] = ($urandom % 8) == 0;
                force_empty = '0;
            end
            4: begin
                s_valid = 1'b1; m_ready = 1'b1; f_in_full = '0;
                force_empty = (cyc < 40) ? 2'b01 : 2'b00;
            end
            6: begin
                s_valid = 1'($urandom % 2); m_ready = 1'($urandom % 2);
                f_in_full = '0; force_empty = '0;
                start = (cyc == 3 || cyc == 10);
            end
            default: begin
                s_valid = ($urandom % 4) != 0;
                m_ready = ($urandom % 3) != 0;
                for (int i = 0; i < NF; i++) begin
                    f_in_full[i]   = ($urandom % 6) == 0;
                    force_empty[i] = ($urandom % 4) == 0;
                end
            end
        endcase
    endtask

    // One image pass; entered and left just after a rising edge.
    task automatic run_pass(input int mode);
        int cyc, stall_rd, win_rd1, dones0;
        bit fin, aborted;
        int lit[TOTAL];
        lit = '{0, 100, 1, 101, 2, 102, 3, 103};
        clear_fifos();
        got.delete();
        dones0 = n_done; stall_rd = 0; win_rd1 = 0; fin = 0; aborted = 0; cyc = 0;
        s_valid = 1'b0; m_ready = 1'b0; f_in_full = '0; force_empty = '0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            drive(mode, cyc);
            @(negedge clock); #1;
            if (mode == 2 && cyc >= 5 && cyc <= 9) begin
                chk("stall_s_ready", s_ready, 1'b0);
                chk("stall_wrreq", f_in_wrreq, 2'b00);
            end
            if (mode == 3 && cyc >= 10 && cyc < 30 && |f_out_rdreq) stall_rd++;
            if (mode == 4 && cyc < 40 && f_out_rdreq[1]) win_rd1++;
            if (mode == 5 && m_acc == 3) begin
                #1 reset = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_s_ready", s_ready, 1'b0);
                chk("rst_wrreq", f_in_wrreq, 2'b00);
                chk("rst_rdreq", f_out_rdreq, 2'b00);
                chk("rst_m_valid", m_valid, 1'b0);
                chk("rst_m_last", m_last, 1'b0);
                chk("rst_m_data", m_data, 32'd0);
                s_valid = 1'b0; m_ready = 1'b0;
                clear_fifos();
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
                aborted = 1;
                fin = 1;
            end
            if (n_done > dones0) fin = 1;
            if (!aborted) begin
                @(posedge clock); #1;
            end
            cyc++;
        end
        if (!fin) chk("pass_timeout", 1'b1, 1'b0);
        s_valid = 1'b0; m_ready = 1'b0; f_in_full = '0; force_empty = '0; start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("done_count", n_done - dones0, (mode == 5) ? 0 : 1);
        if (mode != 5) begin
            chk("rcv0", rcv[0], INP);
            chk("rcv1", rcv[1], INP);
            chk("reads_total", popped[0] + popped[1], TOTAL);
        end
        if (mode == 1) begin
            chk("got_size", got.size(), TOTAL);
            for (int k = 0; k < TOTAL && k < got.size(); k++) chk("literal_order", got[k], lit[k]);
            chk("done_latency", done_cyc - last_acc_cyc, 1);
        end
        if (mode == 3) chk("stall_rdreq", (stall_rd > 1), 1'b0);
        if (mode == 4) chk("order_hold_rd1", win_rd1, 0);
    endtask

    initial begin
        clear_fifos();
        @(posedge clock); #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_s_ready", s_ready, 1'b0);
        chk("reset_wrreq", f_in_wrreq, 2'b00);
        chk("reset_rdreq", f_out_rdreq, 2'b00);
        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_m_last", m_last, 1'b0);
        chk("reset_m_data", m_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_pass(1);
        run_pass(2);
        run_pass(3);
        run_pass(4);
        run_pass(5);
        run_pass(1);
        run_pass(6);
        for (int p = 0; p < 20; p++) run_pass(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
